branch_target_buffer: RTL and testbench



---
 rtl/btb_pkg.sv | 20 ++
 rtl/branch_target_buffer_if.sv | 26 ++
 rtl/btb_storage.sv | 70 +++++++
 rtl/branch_target_buffer.sv | 98 +++++++++
 tb/tb_branch_target_buffer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/btb_pkg.sv
// Shared definitions for the branch target buffer: counter encodings and
// geometry helpers used by the top level and the storage array.
package btb_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctrl_e;

  function automatic int unsigned idx_w(input int unsigned entries);
    return $clog2(entries);
  endfunction

  function automatic int unsigned tag_w(input int unsigned addr_w, input int unsigned entries);
    return addr_w - idx_w(entries) - 2;
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Lookup/update bus between the fetch stage, branch unit and the BTB.
interface branch_target_buffer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              i_Stall;
    logic [ADDR_W-1:0] i_PC;
    logic              i_Invalidate;
    logic              i_WriteEnable;
    logic [ADDR_W-1:0] i_UpdPC;
    logic [ADDR_W-1:0] i_UpdTarget;
    logic [1:0]        i_CtrlOut;
    logic              o_PcMatchValid;
    logic [1:0]        o_CtrlIn;
    logic [ADDR_W-1:0] o_PredTarget;
    logic              o_PredTaken;

    modport master (
        output i_Stall, i_PC, i_Invalidate, i_WriteEnable, i_UpdPC, i_UpdTarget, i_CtrlOut,
        input  o_PcMatchValid, o_CtrlIn, o_PredTarget, o_PredTaken
    );

    modport slave (
        input  i_Stall, i_PC, i_Invalidate, i_WriteEnable, i_UpdPC, i_UpdTarget, i_CtrlOut,
        output o_PcMatchValid, o_CtrlIn, o_PredTarget, o_PredTaken
    );
endinterface

// File: rtl/btb_storage.sv
// Direct-mapped entry array: one write port, one asynchronous read port,
// valid bits with async reset and single-cycle bulk clear.
module btb_storage
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned TAG_W    = tag_w(ADDR_W, ENTRIES),
    parameter logic [1:0]  CTRL_RST = WNT,
    localparam int unsigned IDX_W   = idx_w(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [TAG_W-1:0]  i_wtag,
    input  logic [ADDR_W-1:0] i_wtarget,
    input  logic [1:0]        i_wctrl,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic              o_rvalid,
    output logic [TAG_W-1:0]  o_rtag,
    output logic [ADDR_W-1:0] o_rtarget,
    output logic [1:0]        o_rctrl
);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [1:0]         ctrl_q   [ENTRIES];
    logic [1:0]         ctrl_d   [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];

    // Write is applied after the bulk clear so a simultaneous write survives.
    always_comb begin
        valid_d  = valid_q;
        ctrl_d   = ctrl_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (i_clr) valid_d = '0;
        if (i_we) begin
            valid_d[i_widx]  = 1'b1;
            ctrl_d[i_widx]   = i_wctrl;
            tag_d[i_widx]    = i_wtag;
            target_d[i_widx] = i_wtarget;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) ctrl_q[i] <= CTRL_RST;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign o_rvalid  = valid_q[i_ridx];
    assign o_rtag    = tag_q[i_ridx];
    assign o_rtarget = target_q[i_ridx];
    assign o_rctrl   = ctrl_q[i_ridx];

endmodule

// File: rtl/branch_target_buffer.sv
// IF-stage branch target buffer: registered lookup with write-first bypass,
// stall hold and bulk invalidate, updated from the EX-stage branch unit.
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned ADDR_W   = 32,
    parameter logic [1:0]  CTRL_RST = WNT
) (
    input logic                  clk,
    input logic                  rst,
    branch_target_buffer_if.slave bus
);

    localparam int unsigned IDX_W = idx_w(ENTRIES);
    localparam int unsigned TAG_W = tag_w(ADDR_W, ENTRIES);

    logic [IDX_W-1:0]  lk_idx, upd_idx;
    logic [TAG_W-1:0]  lk_tag, upd_tag;
    logic              rd_valid;
    logic [TAG_W-1:0]  rd_tag;
    logic [ADDR_W-1:0] rd_target;
    logic [1:0]        rd_ctrl;
    logic              unused_pc_lsbs;

    logic              match_q, match_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [ADDR_W-1:0] target_q, target_d;

    assign lk_idx  = bus.i_PC[IDX_W+1:2];
    assign lk_tag  = bus.i_PC[ADDR_W-1:IDX_W+2];
    assign upd_idx = bus.i_UpdPC[IDX_W+1:2];
    assign upd_tag = bus.i_UpdPC[ADDR_W-1:IDX_W+2];
    assign unused_pc_lsbs = ^{bus.i_PC[1:0], bus.i_UpdPC[1:0]};

    btb_storage #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W),
        .TAG_W   (TAG_W),
        .CTRL_RST(CTRL_RST)
    ) u_storage (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (bus.i_Invalidate),
        .i_we     (bus.i_WriteEnable),
        .i_widx   (upd_idx),
        .i_wtag   (upd_tag),
        .i_wtarget(bus.i_UpdTarget),
        .i_wctrl  (bus.i_CtrlOut),
        .i_ridx   (lk_idx),
        .o_rvalid (rd_valid),
        .o_rtag   (rd_tag),
        .o_rtarget(rd_target),
        .o_rctrl  (rd_ctrl)
    );

    // The registered result must reflect the table as it stands after this
    // edge: a same-index write replaces the read data, and a pending
    // invalidate kills any hit that does not come through that write.
    always_comb begin
        match_d  = match_q;
        ctrl_d   = ctrl_q;
        target_d = target_q;
        if (!bus.i_Stall) begin
            if (bus.i_WriteEnable && (upd_idx == lk_idx)) begin
                match_d  = (upd_tag == lk_tag);
                ctrl_d   = bus.i_CtrlOut;
                target_d = bus.i_UpdTarget;
            end else begin
                match_d  = rd_valid && !bus.i_Invalidate && (rd_tag == lk_tag);
                ctrl_d   = rd_ctrl;
                target_d = rd_target;
            end
            if (!match_d) begin
                ctrl_d   = CTRL_RST;
                target_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q  <= 1'b0;
            ctrl_q   <= CTRL_RST;
            target_q <= '0;
        end else begin
            match_q  <= match_d;
            ctrl_q   <= ctrl_d;
            target_q <= target_d;
        end
    end

    assign bus.o_PcMatchValid = match_q;
    assign bus.o_CtrlIn       = ctrl_q;
    assign bus.o_PredTarget   = target_q;
    assign bus.o_PredTaken    = match_q & ctrl_q[1];

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer (ENTRIES=16, ADDR_W=32):
// index = PC[5:2], tag = PC[31:6].
module tb_branch_target_buffer;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_errors;

    branch_target_buffer_if #(.ADDR_W(32)) bus ();

    branch_target_buffer #(
        .ENTRIES (16),
        .ADDR_W  (32),
        .CTRL_RST(2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic m, input logic [1:0] c,
                             input logic [31:0] t, input logic k);
        check({tag, ".match"},  {31'd0, bus.o_PcMatchValid}, {31'd0, m});
        check({tag, ".ctrl"},   {30'd0, bus.o_CtrlIn},       {30'd0, c});
        check({tag, ".target"}, bus.o_PredTarget,            t);
        check({tag, ".taken"},  {31'd0, bus.o_PredTaken},    {31'd0, k});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] pc, input logic [31:0] tgt, input logic [1:0] c);
        bus.i_WriteEnable = 1'b1;
        bus.i_UpdPC       = pc;
        bus.i_UpdTarget   = tgt;
        bus.i_CtrlOut     = c;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.i_Stall = 1'b0;
        bus.i_PC = 32'h0;
        bus.i_Invalidate = 1'b0;
        bus.i_WriteEnable = 1'b0;
        bus.i_UpdPC = 32'h0;
        bus.i_UpdTarget = 32'h0;
        bus.i_CtrlOut = 2'b00;
        #1;
        check_out("reset", 1'b0, 2'b01, 32'h0, 1'b0);
        step();
        step();
        #2 rst = 1'b0;

        bus.i_PC = 32'h40;
        step();
        check_out("cold_miss", 1'b0, 2'b01, 32'h0, 1'b0);

        // 0x40 shares index 0 with 0x100 but carries a different tag.
        write(32'h100, 32'h200, 2'b11);
        step();
        bus.i_WriteEnable = 1'b0;
        check_out("bypass_alias", 1'b0, 2'b01, 32'h0, 1'b0);

        bus.i_PC = 32'h100;
        step();
        check_out("hit_100", 1'b1, 2'b11, 32'h200, 1'b1);

        bus.i_PC = 32'h140;
        step();
        check_out("alias_140", 1'b0, 2'b01, 32'h0, 1'b0);

        bus.i_PC = 32'h100;
        step();
        check_out("rehit_100", 1'b1, 2'b11, 32'h200, 1'b1);

        write(32'h100, 32'h200, 2'b01);
        step();
        bus.i_WriteEnable = 1'b0;
        check_out("bypass_hit", 1'b1, 2'b01, 32'h200, 1'b0);

        bus.i_Stall = 1'b1;
        bus.i_PC = 32'h300;
        write(32'h300, 32'h3A0, 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            bus.i_WriteEnable = 1'b0;
            check_out($sformatf("stall%0d", i), 1'b1, 2'b01, 32'h200, 1'b0);
        end

        bus.i_Stall = 1'b0;
        write(32'h104, 32'h444, 2'b11);
        step();
        bus.i_WriteEnable = 1'b0;
        check_out("hit_300", 1'b1, 2'b10, 32'h3A0, 1'b1);

        bus.i_PC = 32'h104;
        step();
        check_out("hit_104", 1'b1, 2'b11, 32'h444, 1'b1);

        // Invalidate with a write: lookup of 0x300 aliases the written index.
        bus.i_PC = 32'h300;
        bus.i_Invalidate = 1'b1;
        write(32'h180, 32'h1C0, 2'b11);
        step();
        bus.i_Invalidate = 1'b0;
        bus.i_WriteEnable = 1'b0;
        check_out("inv_same", 1'b0, 2'b01, 32'h0, 1'b0);

        bus.i_PC = 32'h104;
        step();
        check_out("inv_104", 1'b0, 2'b01, 32'h0, 1'b0);

        bus.i_PC = 32'h100;
        step();
        check_out("inv_100", 1'b0, 2'b01, 32'h0, 1'b0);

        bus.i_PC = 32'h180;
        step();
        check_out("keep_180", 1'b1, 2'b11, 32'h1C0, 1'b1);

        // Invalidate without a write must kill the hit registered that cycle.
        write(32'h108, 32'h888, 2'b10);
        bus.i_PC = 32'h108;
        step();
        bus.i_WriteEnable = 1'b0;
        check_out("pre_inv_108", 1'b1, 2'b10, 32'h888, 1'b1);
        bus.i_Invalidate = 1'b1;
        step();
        bus.i_Invalidate = 1'b0;
        check_out("inv_only", 1'b0, 2'b01, 32'h0, 1'b0);

        bus.i_PC = 32'h180;
        step();
        check_out("inv_180", 1'b0, 2'b01, 32'h0, 1'b0);

        write(32'h180, 32'h1C0, 2'b11);
        step();
        bus.i_WriteEnable = 1'b0;
        check_out("rewrite_180", 1'b1, 2'b11, 32'h1C0, 1'b1);

        write(32'h180, 32'h555, 2'b00);
        #2 rst = 1'b1;
        #1;
        check_out("async_rst", 1'b0, 2'b01, 32'h0, 1'b0);
        step();
        #2 rst = 1'b0;
        bus.i_WriteEnable = 1'b0;
        step();
        check_out("post_rst_180", 1'b0, 2'b01, 32'h0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
